framebuffer_write_arbiter: RTL and testbench

Shares the two write ports of `framebuffer_master` (`addr_wr1/2`, `data_wr1/2`, `wr1_en/wr2_en`) between up to `N_REQ` pixel producers, such as the sprite, track and HUD renderers.
- Grants up to two requests per cycle, round-robin, over a valid/ready handshake.
- Never issues two writes to the same address in one cycle.
- Stalls all producers while the back buffer is being cleared (`fb_resetting`).
- Discards and counts out-of-range addresses.

---
 rtl/fb_pkg.sv | 18 +
 rtl/framebuffer_write_arbiter_rr_pick2.sv | 58 +++++
 rtl/framebuffer_write_arbiter.sv | 127 ++++++++++++
 tb/tb_framebuffer_write_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and pixel-write types used by the write path.
package fb_pkg;

    localparam int FRAMEBUFFER_SIZE      = 19200;
    localparam int FRAMEBUFFER_ADDR_SIZE = 15;
    localparam int FB_ADDR_W             = FRAMEBUFFER_ADDR_SIZE + 1;
    localparam int FB_DATA_W             = 4;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_DATA_W-1:0] fb_pixel_t;

    typedef struct packed {
        fb_addr_t  addr;
        fb_pixel_t data;
        logic      en;
    } fb_write_t;

endpackage

// File: rtl/framebuffer_write_arbiter_rr_pick2.sv
// Combinational two-slot round-robin picker; slot B must target a different address than slot A.
// Zero latency; no state, the caller owns the pointer and the handshake.
module rr_pick2
    import fb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int IDX_W  = 2
) (
    input  logic [N_REQ-1:0]             valid_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0] addr_i,
    input  logic [IDX_W-1:0]             ptr_i,
    output logic                         vld_a_o,
    output logic                         vld_b_o,
    output logic [IDX_W-1:0]             idx_a_o,
    output logic [IDX_W-1:0]             idx_b_o,
    output logic [N_REQ-1:0]             gnt_a_o,
    output logic [N_REQ-1:0]             gnt_b_o,
    output logic [N_REQ-1:0]             skip_o
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] idx;

    always_comb begin
        vld_a_o = 1'b0;
        vld_b_o = 1'b0;
        idx_a_o = '0;
        idx_b_o = '0;
        skip_o  = '0;
        pos     = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(N_REQ)) begin
                pos = pos - (IDX_W+1)'(N_REQ);
            end
            idx = pos[IDX_W-1:0];
            if (valid_i[idx]) begin
                if (!vld_a_o) begin
                    vld_a_o = 1'b1;
                    idx_a_o = idx;
                end else if (!vld_b_o) begin
                    // Same-address requesters wait so the two ports never collide.
                    if (addr_i[idx] != addr_i[idx_a_o]) begin
                        vld_b_o = 1'b1;
                        idx_b_o = idx;
                    end else begin
                        skip_o[idx] = 1'b1;
                    end
                end
            end
        end
        gnt_a_o = vld_a_o ? (N_REQ'(1) << idx_a_o) : '0;
        gnt_b_o = vld_b_o ? (N_REQ'(1) << idx_b_o) : '0;
    end

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Shares the two framebuffer write ports among N_REQ pixel producers, two grants per cycle round-robin.
// One registered stage to the ports; ready is combinational and held low during reset or buffer clear.
module framebuffer_write_arbiter
    import fb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    input  logic                         fb_resetting,
    output logic [ADDR_W-1:0]            addr_wr1,
    output logic [DATA_W-1:0]            data_wr1,
    output logic                         wr1_en,
    output logic [ADDR_W-1:0]            addr_wr2,
    output logic [DATA_W-1:0]            data_wr2,
    output logic                         wr2_en,
    output logic [CNT_W-1:0]             drop_count,
    output logic                         busy
);

    localparam int                IDX_W    = $clog2(N_REQ);
    localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FRAMEBUFFER_SIZE);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              en;
    } port_t;

    port_t            port1_q, port1_d, port2_q, port2_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W:0]   drop_sum;
    logic [1:0]       drop_inc;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             busy_q;

    logic             vld_a, vld_b;
    logic [IDX_W-1:0] idx_a, idx_b;
    logic [N_REQ-1:0] gnt_a, gnt_b, skip;
    logic             grant_ok, fire_a, fire_b, in_rng_a, in_rng_b;

    rr_pick2 #(
        .N_REQ (N_REQ),
        .ADDR_W(ADDR_W),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid_i(req_valid),
        .addr_i (req_addr),
        .ptr_i  (rr_ptr_q),
        .vld_a_o(vld_a),
        .vld_b_o(vld_b),
        .idx_a_o(idx_a),
        .idx_b_o(idx_b),
        .gnt_a_o(gnt_a),
        .gnt_b_o(gnt_b),
        .skip_o (skip)
    );

    assign grant_ok  = reset && !fb_resetting;
    assign fire_a    = vld_a && grant_ok;
    assign fire_b    = vld_b && grant_ok;
    assign req_ready = grant_ok ? ((gnt_a | gnt_b) & ~skip) : '0;
    assign in_rng_a  = req_addr[idx_a] < FB_LIMIT;
    assign in_rng_b  = req_addr[idx_b] < FB_LIMIT;

    always_comb begin
        port1_d    = port1_q;
        port2_d    = port2_q;
        port1_d.en = 1'b0;
        port2_d.en = 1'b0;
        if (fire_a) begin
            port1_d.addr = req_addr[idx_a];
            port1_d.data = req_data[idx_a];
            port1_d.en   = in_rng_a;
        end
        if (fire_b) begin
            port2_d.addr = req_addr[idx_b];
            port2_d.data = req_data[idx_b];
            port2_d.en   = in_rng_b;
        end

        drop_inc = 2'(fire_a && !in_rng_a) + 2'(fire_b && !in_rng_b);
        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_inc);
        drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

        // Resume just after the last requester served, which is slot B when present.
        rr_ptr_d = rr_ptr_q;
        if (fire_b) begin
            rr_ptr_d = (idx_b == IDX_W'(N_REQ-1)) ? '0 : idx_b + IDX_W'(1);
        end else if (fire_a) begin
            rr_ptr_d = (idx_a == IDX_W'(N_REQ-1)) ? '0 : idx_a + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            port1_q  <= '0;
            port2_q  <= '0;
            drop_q   <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            port1_q  <= port1_d;
            port2_q  <= port2_d;
            drop_q   <= drop_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= port1_d.en | port2_d.en;
        end
    end

    assign addr_wr1   = port1_q.addr;
    assign data_wr1   = port1_q.data;
    assign wr1_en     = port1_q.en;
    assign addr_wr2   = port2_q.addr;
    assign data_wr2   = port2_q.data;
    assign wr2_en     = port2_q.en;
    assign drop_count = drop_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Directed bench for framebuffer_write_arbiter with hand-computed expectations.
module tb_framebuffer_write_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 4;
    localparam int CW  = 4;
    localparam int FBS = 19200;

    logic                 clock, reset, fb_resetting;
    logic [N-1:0]         req_valid, req_ready;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_data;
    logic [AW-1:0]        addr_wr1, addr_wr2;
    logic [DW-1:0]        data_wr1, data_wr2;
    logic                 wr1_en, wr2_en, busy;
    logic [CW-1:0]        drop_count;

    int checks = 0;
    int errors = 0;
    int gcnt [N];

    framebuffer_write_arbiter #(
        .N_REQ (N),
        .ADDR_W(AW),
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fb_resetting(fb_resetting),
        .addr_wr1    (addr_wr1),
        .data_wr1    (data_wr1),
        .wr1_en      (wr1_en),
        .addr_wr2    (addr_wr2),
        .data_wr2    (data_wr2),
        .wr2_en      (wr2_en),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        reset        = 1'b1;
        fb_resetting = 1'b0;
        req_valid    = '1;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = AW'(10 + i);
            req_data[i] = DW'(i);
        end
        #1 reset = 1'b0;
        #1;
        chk("rst_wr1_en", wr1_en, 0);
        chk("rst_wr2_en", wr2_en, 0);
        chk("rst_addr_wr1", addr_wr1, 0);
        chk("rst_addr_wr2", addr_wr2, 0);
        chk("rst_data_wr1", data_wr1, 0);
        chk("rst_data_wr2", data_wr2, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        tick();
        tick();
        chk("rst_hold_en", wr1_en | wr2_en, 0);
        chk("rst_hold_ready", req_ready, 0);

        // Single requester; first grant right after reset release.
        req_valid   = 4'b0001;
        req_addr[0] = 16'd100;
        req_data[0] = 4'd3;
        reset       = 1'b1;
        #1 chk("single_ready", req_ready, 4'b0001);
        tick();
        chk("single_wr1_en", wr1_en, 1);
        chk("single_addr_wr1", addr_wr1, 100);
        chk("single_data_wr1", data_wr1, 3);
        chk("single_wr2_en", wr2_en, 0);
        chk("single_busy", busy, 1);

        req_valid = '0;
        #1 chk("idle_ready", req_ready, 0);
        tick();
        chk("idle_wr1_en", wr1_en, 0);
        chk("idle_wr2_en", wr2_en, 0);
        chk("idle_busy", busy, 0);
        chk("idle_addr_hold", addr_wr1, 100);

        // Grant requester 3 alone to bring the pointer back to 0.
        req_valid = 4'b1000;
        tick();

        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = AW'(10 + i);
            req_data[i] = DW'(i);
        end
        for (int c = 0; c < 100; c++) begin
            #1 chk("fair_ready", req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            for (int i = 0; i < N; i++) if (req_ready[i]) gcnt[i]++;
            tick();
            chk("fair_addr1", addr_wr1, (c % 2 == 0) ? 10 : 12);
            chk("fair_addr2", addr_wr2, (c % 2 == 0) ? 11 : 13);
        end
        for (int i = 0; i < N; i++) chk("fair_share", gcnt[i], 50);

        // Pointer 0 -> 1 via a lone grant to requester 0.
        req_valid = 4'b0001;
        tick();
        req_valid   = 4'b1110;
        req_addr[1] = 16'd500;
        req_addr[2] = 16'd500;
        req_addr[3] = 16'd7;
        req_data[1] = 4'd1;
        req_data[2] = 4'd2;
        req_data[3] = 4'd5;
        #1 chk("coll_ready", req_ready, 4'b1010);
        tick();
        chk("coll_addr_wr1", addr_wr1, 500);
        chk("coll_data_wr1", data_wr1, 1);
        chk("coll_wr1_en", wr1_en, 1);
        chk("coll_addr_wr2", addr_wr2, 7);
        chk("coll_data_wr2", data_wr2, 5);
        chk("coll_wr2_en", wr2_en, 1);
        req_valid = 4'b0100;
        #1 chk("coll_next_ready", req_ready, 4'b0100);
        tick();
        chk("coll_next_data", data_wr1, 2);
        chk("coll_next_wr1_en", wr1_en, 1);
        chk("coll_next_wr2_en", wr2_en, 0);

        // Out-of-range at exactly the framebuffer size, then the last legal pixel.
        req_valid   = 4'b0001;
        req_addr[0] = AW'(FBS);
        req_data[0] = 4'd9;
        #1 chk("oor_ready", req_ready, 4'b0001);
        tick();
        chk("oor_wr1_en", wr1_en, 0);
        chk("oor_busy", busy, 0);
        chk("oor_drop", drop_count, 1);
        req_valid   = 4'b0010;
        req_addr[1] = AW'(FBS - 1);
        #1 chk("edge_ready", req_ready, 4'b0010);
        tick();
        chk("edge_wr1_en", wr1_en, 1);
        chk("edge_addr_wr1", addr_wr1, FBS - 1);
        chk("edge_drop", drop_count, 1);

        // Two drops per cycle drive the 4-bit counter into saturation.
        req_valid   = 4'b0011;
        req_addr[0] = AW'(FBS);
        req_addr[1] = 16'd40000;
        #1 chk("sat_ready", req_ready, 4'b0011);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("sat_drop", drop_count, (1 + 2 * k > 15) ? 15 : 1 + 2 * k);
            chk("sat_wr2_en", wr2_en, 0);
        end

        // Buffer clear with requests pending; pointer is 2 here.
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = AW'(1000 + i);
            req_data[i] = DW'(i + 4);
        end
        #1 chk("clr_pre_ready", req_ready, 4'b1100);
        tick();
        fb_resetting = 1'b1;
        #1;
        chk("clr_ready_rise", req_ready, 0);
        chk("clr_late_wr1_en", wr1_en, 1);
        chk("clr_late_addr1", addr_wr1, 1002);
        chk("clr_late_wr2_en", wr2_en, 1);
        chk("clr_late_addr2", addr_wr2, 1003);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("clr_ready", req_ready, 0);
            chk("clr_no_write", wr1_en | wr2_en, 0);
        end
        fb_resetting = 1'b0;
        #1 chk("clr_resume_ready", req_ready, 4'b0011);
        tick();
        chk("clr_resume_addr1", addr_wr1, 1000);
        chk("clr_resume_addr2", addr_wr2, 1001);
        chk("clr_resume_wr1_en", wr1_en, 1);

        // Mid-stream reset while writes are on the ports.
        reset = 1'b0;
        #1;
        chk("mrst_wr1_en", wr1_en, 0);
        chk("mrst_wr2_en", wr2_en, 0);
        chk("mrst_addr_wr1", addr_wr1, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_drop", drop_count, 0);
        chk("mrst_ready", req_ready, 0);
        tick();
        chk("mrst_no_write", wr1_en | wr2_en, 0);
        reset = 1'b1;
        #1 chk("mrst_release_ready", req_ready, 4'b0011);
        tick();
        chk("mrst_first_addr1", addr_wr1, 1000);
        chk("mrst_first_addr2", addr_wr2, 1001);
        chk("mrst_first_drop", drop_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
